cpu8_core: RTL and testbench
============================

// Module: cpu8_core
// PURPOSE
//   8-bit multi-cycle processor core: byte-loaded program RAM, control-unit FSM, PC and ALU datapath.
//   Top-level execution block. Instruction = opcode + two immediate operands; result in register C.
//   Program is loaded byte-serially through Data_w/ram_we, then executed from slot 0.
// PARAMETERS
//   SLOTS    64  instruction slots; PC width = clog2(SLOTS) = 6
//   DW        8  datapath / byte width
// PORTS
//   clk      in   1  single clock; everything on posedge
//   rst      in   1  asynchronous, active-high reset
//   Data_w   in   8  program byte to write into RAM
//   ram_we   in   1  write strobe for Data_w; also freezes execution
//   alu_out  out  8  register C (last ALU result)
//   flags    out  8  {3'b0, P, V, N, Z, C}; bit0 = C
// BEHAVIOUR
//   - One clock domain; reset is asynchronous and active-high.
//   - Reset clears PC, IR, Op1, Op2, A, B, C, flags and write pointer wp. FSM enters FETCH.
//     alu_out = 0 and flags = 0 after reset.
//   - RAM contents are zero at power-up and are NOT cleared by rst.
//   - RAM holds 3*SLOTS bytes. Slot k = bytes {3k: opcode, 3k+1: Op1, 3k+2: Op2}. Reads are combinational at PC.
//   - Load: each posedge with ram_we=1 writes mem[wp] <= Data_w and does wp++. wp wraps 191 -> 0.
//     The FSM and all CPU registers hold for that cycle.
//   - FSM states, one edge each, 5 cycles per instruction:
//       FETCH  : IR, Op1, Op2 <= slot[PC]
//       LOAD_A : A <= Op1
//       LOAD_B : B <= Op2
//       EXEC   : C, flags <= ALU(A, B, IR)
//       NEXT   : PC <= PC+1, wraps 63 -> 0; go to FETCH
//   - EXEC with IR=0xFF (HALT): go to HALTED. HALTED holds until rst; C and flags are unchanged.
//   - Opcodes:
//       00 NOP      01 ADD A+B   02 SUB A-B   03 AND   04 OR    05 XOR
//       06 NOT A    07 SHL A     08 SHR A     09 INC A 0A DEC A 0B MUL (low byte)
//       FF HALT     any other opcode = NOP
//   - NOP leaves C and flags unchanged. All other opcodes update C and all flags.
//   - Flag rules:
//       Z: result == 0
//       N: result[7]
//       P: even number of 1s in result
//       C, ADD/INC: carry out of bit 7
//       C, SUB/DEC: borrow (A < subtrahend)
//       C, SHL/SHR: bit shifted out
//       C, MUL: high byte != 0
//       C, logic ops: 0
//       V, ADD/SUB/INC/DEC: signed overflow
//       V, MUL: equals C
//       V, all others: 0
//   - Shifts fill with 0. 8-bit arithmetic wraps.
//   - rst mid-instruction aborts it and restarts at FETCH with PC = 0.
//   - ram_we during execution stalls exactly the strobed cycles, then execution resumes in the same state.
// TESTING
//   1. Assert rst at any time -> alu_out=00, flags=00, PC=0, FSM=FETCH; RAM bytes retained.
//   2. Load 01 05 03, reset -> 4th edge after reset release: alu_out=08, flags=00; 5th edge: PC=1.
//   3. Load 01 FF 01 -> alu_out=00, flags=13 (C, Z, P).
//   4. Load 02 03 05 -> alu_out=FE, flags=05 (C, N). Load 0B 10 10 -> alu_out=00, flags=1B.
//   5. Load 01 02 02, FF 00 00 -> alu_out=04; after HALT, outputs and PC stay constant for 20 cycles.
//   6. Pulse ram_we for 2 cycles during LOAD_B -> result is delayed by exactly 2 cycles; value unchanged.

Source files
------------

// File: rtl/cpu8_if.sv
// Program-load and result bus of the 8-bit core: bytes and strobe in, register C and flags out.
interface cpu8_if #(parameter int DW = 8);
    logic [DW-1:0] Data_w;
    logic          ram_we;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] flags;

    modport master (output Data_w, output ram_we, input alu_out, input flags);
    modport slave  (input Data_w, input ram_we, output alu_out, output flags);
endinterface

// File: rtl/cpu8_core.sv
// 8-bit multi-cycle core: byte-loaded program RAM, 5-state control FSM, PC and ALU.
// Each slot is {opcode, Op1, Op2}; results land in register C with a 5-bit flag set.
module cpu8_core #(
    parameter int SLOTS = 64,
    parameter int DW    = 8
) (
    input  logic    clk,
    input  logic    rst,
    cpu8_if.slave   bus
);
    localparam int PW    = $clog2(SLOTS);
    localparam int MEMSZ = 3 * SLOTS;
    localparam int AW    = $clog2(MEMSZ);

    typedef enum logic [2:0] {
        S_FETCH, S_LOAD_A, S_LOAD_B, S_EXEC, S_NEXT, S_HALT
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_mem [MEMSZ];
    logic [AW-1:0]   r_wp;
    logic [PW-1:0]   r_pc;
    logic [DW-1:0]   r_ir, r_op1, r_op2, r_a, r_b, r_c, r_flags;

    logic [AW-1:0]   w_base;
    logic [DW-1:0]   w_opb, w_res;
    logic [DW:0]     w_sum, w_dif;
    logic [2*DW-1:0] w_prod;
    logic            w_c, w_v, w_upd;

    // RAM has no reset so a program survives rst
    always_ff @(posedge clk) begin
        if (bus.ram_we)
            r_mem[r_wp] <= bus.Data_w;
    end

    assign w_base = AW'(r_pc) * AW'(3);
    assign w_opb  = (r_ir == 8'h09 || r_ir == 8'h0A) ? DW'(1) : r_b;
    assign w_sum  = {1'b0, r_a} + {1'b0, w_opb};
    assign w_dif  = {1'b0, r_a} - {1'b0, w_opb};
    assign w_prod = (2*DW)'(r_a) * (2*DW)'(r_b);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b1;
        case (r_ir)
            8'h01, 8'h09: begin
                {w_c, w_res} = w_sum;
                w_v = (r_a[DW-1] == w_opb[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);
            end
            8'h02, 8'h0A: begin
                {w_c, w_res} = w_dif;
                w_v = (r_a[DW-1] != w_opb[DW-1]) && (w_dif[DW-1] != r_a[DW-1]);
            end
            8'h03: w_res = r_a & r_b;
            8'h04: w_res = r_a | r_b;
            8'h05: w_res = r_a ^ r_b;
            8'h06: w_res = ~r_a;
            8'h07: begin w_res = {r_a[DW-2:0], 1'b0}; w_c = r_a[DW-1]; end
            8'h08: begin w_res = {1'b0, r_a[DW-1:1]}; w_c = r_a[0]; end
            8'h0B: begin
                w_res = w_prod[DW-1:0];
                w_c   = |w_prod[2*DW-1:DW];
                w_v   = w_c;
            end
            default: w_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wp    <= '0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_flags <= '0;
        end else if (bus.ram_we) begin
            // a load strobe freezes the whole CPU for that cycle
            r_wp <= (r_wp == AW'(MEMSZ - 1)) ? '0 : r_wp + AW'(1);
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= r_mem[w_base];
                    r_op1   <= r_mem[w_base + AW'(1)];
                    r_op2   <= r_mem[w_base + AW'(2)];
                    r_state <= S_LOAD_A;
                end
                S_LOAD_A: begin r_a <= r_op1; r_state <= S_LOAD_B; end
                S_LOAD_B: begin r_b <= r_op2; r_state <= S_EXEC;   end
                S_EXEC: begin
                    if (r_ir == 8'hFF) begin
                        r_state <= S_HALT;
                    end else begin
                        if (w_upd) begin
                            r_c     <= w_res;
                            r_flags <= {3'b000, ~^w_res, w_v, w_res[DW-1], (w_res == '0), w_c};
                        end
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_pc    <= (r_pc == PW'(SLOTS - 1)) ? '0 : r_pc + PW'(1);
                    r_state <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign bus.alu_out = r_c;
    assign bus.flags   = r_flags;
endmodule

// File: tb/tb_cpu8_core.sv
// Scoreboard bench for cpu8_core: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_cpu8_core;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   base;

    cpu8_if #(.DW(8)) bif ();

    cpu8_core #(.SLOTS(64), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] alu;
        logic [7:0] fl;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.at < cyc || bif.alu_out !== e.alu || bif.flags !== e.fl) begin
                n_err++;
                $display("FAIL %s @cyc %0d (due %0d): got alu=%h flags=%h, want alu=%h flags=%h",
                         e.nm, cyc, e.at, bif.alu_out, bif.flags, e.alu, e.fl);
            end
        end
    end

    task automatic expect_at(input int at, input logic [7:0] a, input logic [7:0] f, input string nm);
        exp_t x;
        x.at = at; x.alu = a; x.fl = f; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        base = cyc;
        expect_at(base, 8'h00, 8'h00, nm);
    endtask

    task automatic load_slot(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] by [3];
        by[0] = op; by[1] = a; by[2] = b;
        for (int i = 0; i < 3; i++) begin
            bif.Data_w = by[i];
            bif.ram_we = 1'b1;
            step(1);
        end
        bif.ram_we = 1'b0;
    endtask

    logic [7:0] mop [11];
    logic [7:0] ma  [11];
    logic [7:0] mb  [11];
    logic [7:0] mr  [11];
    logic [7:0] mf  [11];

    initial begin
        rst = 1'b1;
        bif.ram_we = 1'b0;
        bif.Data_w = 8'h00;
        step(2);
        rst = 1'b0;
        expect_at(cyc, 8'h00, 8'h00, "por");

        // 5 + 3
        load_slot(8'h01, 8'h05, 8'h03);
        load_slot(8'hFF, 8'h00, 8'h00);
        do_reset("rst_add");
        expect_at(base + 3, 8'h00, 8'h00, "add_early");
        expect_at(base + 4, 8'h08, 8'h00, "add");
        for (int i = 9; i < 30; i++) expect_at(base + i, 8'h08, 8'h00, "halt_hold1");
        step(30);

        // FF + 1: carry, zero, parity
        do_reset("rst_l2");
        load_slot(8'h01, 8'hFF, 8'h01);
        load_slot(8'hFF, 8'h00, 8'h00);
        do_reset("rst_carry");
        expect_at(base + 4, 8'h00, 8'h13, "add_carry");
        step(12);

        // 3 - 5 then 0x10 * 0x10
        do_reset("rst_l3");
        load_slot(8'h02, 8'h03, 8'h05);
        load_slot(8'h0B, 8'h10, 8'h10);
        load_slot(8'hFF, 8'h00, 8'h00);
        do_reset("rst_submul");
        expect_at(base + 4, 8'hFE, 8'h05, "sub_borrow");
        expect_at(base + 8, 8'hFE, 8'h05, "sub_hold");
        expect_at(base + 9, 8'h00, 8'h1B, "mul_ovf");
        step(16);

        // 2 + 2 then HALT; held for 20+ cycles
        do_reset("rst_l4");
        load_slot(8'h01, 8'h02, 8'h02);
        load_slot(8'hFF, 8'h00, 8'h00);
        do_reset("rst_halt");
        expect_at(base + 4, 8'h04, 8'h00, "add4");
        for (int i = 10; i < 32; i++) expect_at(base + i, 8'h04, 8'h00, "halt_hold2");
        step(33);

        // reset mid-instruction restarts at slot 0 with RAM intact
        do_reset("rst_rerun");
        expect_at(base + 4, 8'h04, 8'h00, "rerun");
        step(7);
        do_reset("rst_mid");
        expect_at(base + 4, 8'h04, 8'h00, "mid_restart");
        step(12);

        // ram_we for 2 cycles during LOAD_B delays the result by 2
        do_reset("rst_l5");
        load_slot(8'h01, 8'h05, 8'h03);
        load_slot(8'hFF, 8'h00, 8'h00);
        do_reset("rst_stall");
        step(2);
        bif.ram_we = 1'b1; bif.Data_w = 8'h01;
        step(1);
        bif.Data_w = 8'h05;
        step(1);
        bif.ram_we = 1'b0;
        expect_at(base + 5, 8'h00, 8'h00, "stall_early");
        expect_at(base + 6, 8'h08, 8'h00, "stall_result");
        step(10);

        // opcode sweep: op, A, B, expected C, expected flags
        mop = '{8'h05, 8'h08, 8'h0A, 8'h09, 8'h00, 8'h06, 8'h07, 8'h03, 8'h04, 8'h0C, 8'hFF};
        ma  = '{8'h0F, 8'h81, 8'h00, 8'h7F, 8'h12, 8'h0F, 8'h80, 8'hF0, 8'h00, 8'h55, 8'h00};
        mb  = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h34, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h66, 8'h00};
        mr  = '{8'h33, 8'h40, 8'hFF, 8'h80, 8'h80, 8'hF0, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
        mf  = '{8'h10, 8'h01, 8'h15, 8'h0C, 8'h0C, 8'h14, 8'h13, 8'h10, 8'h12, 8'h12, 8'h12};
        do_reset("rst_l6");
        for (int k = 0; k < 11; k++) load_slot(mop[k], ma[k], mb[k]);
        do_reset("rst_sweep");
        for (int k = 0; k < 10; k++)
            expect_at(base + 5*k + 4, mr[k], mf[k], $sformatf("op%02h", mop[k]));
        expect_at(base + 70, 8'h00, 8'h12, "sweep_halt");

        for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_err += q.size();
            $display("FAIL timeout: got %0d pending checks, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
